// File: rtl/spike_window_scheduler.sv
// Collects per-timestep spike vectors into per-neuron window patterns and
// streams each completed window to the TPPE over a valid/ready link.
module spike_window_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int T_WINDOW  = 16,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 step_valid,
    output logic                 step_ready,
    input  logic [N_NEURONS-1:0] spike_vec,
    output logic                 pat_valid,
    input  logic                 pat_ready,
    output logic [T_WINDOW-1:0]  pat_data,
    output logic [IDX_W-1:0]     pat_neuron,
    output logic                 pat_last,
    output logic                 window_done
);

    localparam int CNT_W = $clog2(T_WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(T_WINDOW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } drain_state_t;

    drain_state_t        state;
    logic [CNT_W-1:0]    cap_cnt;
    logic [T_WINDOW-1:0] cap_bank   [N_NEURONS];
    logic [T_WINDOW-1:0] drain_bank [N_NEURONS];

    logic             step_accept;
    logic             swap;
    logic             pat_hs;
    logic [IDX_W-1:0] next_idx;

    assign step_ready  = (cap_cnt != CNT_FULL) && !flush;
    assign step_accept = step_valid && step_ready;
    // A full capture bank waits here until the drain side is idle.
    assign swap        = (cap_cnt == CNT_FULL) && (state == IDLE) && !flush;
    assign pat_hs      = pat_valid && pat_ready;
    assign next_idx    = pat_neuron + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_cnt <= '0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                cap_bank[i] <= '0;
            end
        end else if (flush || swap) begin
            cap_cnt <= '0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                cap_bank[i] <= '0;
            end
        end else if (step_accept) begin
            cap_cnt <= cap_cnt + 1'b1;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                cap_bank[i] <= {cap_bank[i][T_WINDOW-2:0], spike_vec[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pat_valid   <= 1'b0;
            pat_data    <= '0;
            pat_neuron  <= '0;
            pat_last    <= 1'b0;
            window_done <= 1'b0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                drain_bank[i] <= '0;
            end
        end else begin
            window_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (swap) begin
                        drain_bank <= cap_bank;
                        state      <= SEND;
                        pat_valid  <= 1'b1;
                        pat_data   <= cap_bank[0];
                        pat_neuron <= '0;
                        pat_last   <= 1'b0;
                    end
                end
                SEND: begin
                    if (pat_hs) begin
                        if (pat_last) begin
                            state       <= IDLE;
                            pat_valid   <= 1'b0;
                            pat_data    <= '0;
                            pat_neuron  <= '0;
                            pat_last    <= 1'b0;
                            window_done <= 1'b1;
                        end else begin
                            pat_data   <= drain_bank[next_idx];
                            pat_neuron <= next_idx;
                            pat_last   <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_window_scheduler.sv
// Directed bench for spike_window_scheduler: a reference capture model pushes
// expected patterns to a queue, a monitor pops and compares each handshake.
module tb_spike_window_scheduler;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int IW = 2;

    typedef logic [T+IW:0] exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          step_valid = 1'b0;
    logic          step_ready;
    logic [N-1:0]  spike_vec = '0;
    logic          pat_valid;
    logic          pat_ready = 1'b1;
    logic [T-1:0]  pat_data;
    logic [IW-1:0] pat_neuron;
    logic          pat_last;
    logic          window_done;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int done_pulses = 0;
    int win_pushed = 0;
    int win_aborted = 0;
    int stall_cycles = 0;

    exp_t          exp_q[$];
    logic [T-1:0]  mcap[N];
    int            mcnt = 0;
    logic          exp_done = 1'b0;
    logic          have_prev = 1'b0;
    logic [T-1:0]  prev_data;
    logic [IW-1:0] prev_neuron;

    always #5 clk = ~clk;

    spike_window_scheduler #(
        .N_NEURONS (N),
        .T_WINDOW  (T),
        .IDX_W     (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .step_valid  (step_valid),
        .step_ready  (step_ready),
        .spike_vec   (spike_vec),
        .pat_valid   (pat_valid),
        .pat_ready   (pat_ready),
        .pat_data    (pat_data),
        .pat_neuron  (pat_neuron),
        .pat_last    (pat_last),
        .window_done (window_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: scoreboard pops, window_done timing, hold stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_done  = 1'b0;
            have_prev = 1'b0;
        end else begin
            chk("window_done", window_done, exp_done);
            if (window_done) done_pulses++;
            exp_done = 1'b0;
            if (have_prev && pat_valid) begin
                chk("hold_data", pat_data, prev_data);
                chk("hold_neuron", pat_neuron, prev_neuron);
            end
            have_prev = 1'b0;
            if (pat_valid && pat_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    chk("pat_data", pat_data, e[T-1:0]);
                    chk("pat_neuron", pat_neuron, e[T+IW-1:T]);
                    chk("pat_last", pat_last, e[T+IW]);
                    if (e[T+IW]) exp_done = 1'b1;
                end
            end else if (pat_valid) begin
                have_prev   = 1'b1;
                prev_data   = pat_data;
                prev_neuron = pat_neuron;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < N; i++) mcap[i] = '0;
        mcnt = 0;
    endtask

    task automatic model_accept(input logic [N-1:0] vec);
        for (int i = 0; i < N; i++) mcap[i] = {mcap[i][T-2:0], vec[i]};
        mcnt++;
        if (mcnt == T) begin
            for (int i = 0; i < N; i++) begin
                exp_q.push_back({(i == N-1), IW'(i), mcap[i]});
                mcap[i] = '0;
            end
            mcnt = 0;
            win_pushed++;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_step(input logic [N-1:0] vec, input bit rand_gap);
        bit ok;
        ok = 1'b0;
        if (rand_gap) begin
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(1) == 0) break;
                step_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        step_valid = 1'b1;
        spike_vec  = vec;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (step_ready) begin
                ok = 1'b1;
                break;
            end
            stall_cycles++;
        end
        if (!ok) begin
            chk("step_timeout", 0, 1);
            step_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_accept(vec);
            step_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_done", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [N-1:0] w1_vec(input int s);
        return (s == 0) ? 4'b1001 : 4'b1000;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int p0;
        bit seen;
        model_clear();

        // Reset state
        @(negedge clk);
        chk("rst_pat_valid", pat_valid, 0);
        chk("rst_pat_data", pat_data, 0);
        chk("rst_pat_neuron", pat_neuron, 0);
        chk("rst_pat_last", pat_last, 0);
        chk("rst_window_done", window_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_step_ready", step_ready, 1);
        @(posedge clk);
        #1;

        // 1: basic window, pat_valid latency, single window_done
        d0 = done_pulses;
        for (int s = 0; s < T; s++) send_step(w1_vec(s), 1'b0);
        @(negedge clk);
        chk("t1_valid_before_swap", pat_valid, 0);
        @(negedge clk);
        chk("t1_valid_after_swap", pat_valid, 1);
        wait_drain();
        chk("t1_done_pulses", done_pulses - d0, 1);
        @(posedge clk);
        #1;

        // 2: stalled sink, three windows offered
        p0 = pops;
        pat_ready = 1'b0;
        for (int s = 0; s < 2*T; s++) send_step(N'($urandom), 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t2_backpressure", step_ready, 0);
            chk("t2_valid_held", pat_valid, 1);
            chk("t2_data_held", pat_data, exp_q[0][T-1:0]);
        end
        chk("t2_no_pops_stalled", pops - p0, 0);
        @(posedge clk);
        #1 pat_ready = 1'b1;
        for (int s = 0; s < T; s++) send_step(N'($urandom), 1'b0);
        wait_drain();
        chk("t2_all_patterns", pops - p0, 3*N);
        @(posedge clk);
        #1;

        // 3: random step_valid gaps, same spikes as test 1
        for (int s = 0; s < T; s++) send_step(w1_vec(s), 1'b1);
        wait_drain();
        @(posedge clk);
        #1;

        // 4: flush discards partial window and same-cycle step
        for (int s = 0; s < 5; s++) send_step('1, 1'b0);
        flush      = 1'b1;
        step_valid = 1'b1;
        spike_vec  = '1;
        @(negedge clk);
        chk("t4_flush_ready", step_ready, 0);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        step_valid = 1'b0;
        model_clear();
        for (int s = 0; s < T; s++) send_step('0, 1'b0);
        wait_drain();
        @(posedge clk);
        #1;

        // 5: reset during SEND at idx 2
        pat_ready = 1'b0;
        for (int s = 0; s < T; s++) send_step(N'($urandom), 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (pat_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_valid_seen", seen, 1);
        @(posedge clk);
        #1 pat_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 pat_ready = 1'b0;
        @(negedge clk);
        chk("t5_idx2", pat_neuron, 2);
        chk("t5_valid_idx2", pat_valid, 1);
        d0 = done_pulses;
        rst = 1'b1;
        #1;
        chk("t5_valid_cleared", pat_valid, 0);
        chk("t5_data_cleared", pat_data, 0);
        exp_q.delete();
        model_clear();
        win_aborted++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pat_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_done", done_pulses - d0, 0);
        chk("t5_step_ready", step_ready, 1);
        @(posedge clk);
        #1;
        for (int s = 0; s < T; s++) send_step(N'($urandom), 1'b0);
        wait_drain();
        @(posedge clk);
        #1;

        // 6: continuous stream, one bubble per window
        stall_cycles = 0;
        for (int s = 0; s < 4*T; s++) send_step(N'($urandom), 1'b0);
        @(negedge clk);
        chk("t6_last_bubble", step_ready, 0);
        @(negedge clk);
        chk("t6_ready_after_bubble", step_ready, 1);
        chk("t6_stall_cycles", stall_cycles, 3);
        wait_drain();

        chk("total_done_pulses", done_pulses, win_pushed - win_aborted);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
